// File: rtl/cube_scan_ctrl.sv
// Layer-multiplexed LED cube scanner: double-buffers incoming frames and serialises
// one 64-bit layer at a time into the external shift chain, latches it, then dwells.
module cube_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scan_en,
  input  logic [511:0] frame_cube_flat,
  input  logic         frame_valid,
  output logic         ser_data,
  output logic         ser_clk,
  output logic         ser_latch,
  output logic [7:0]   layer_en,
  output logic         frame_done,
  output logic         swap_pending,
  output logic [7:0]   drop_cnt
);

  localparam int unsigned FRAME_W    = 512;
  localparam int unsigned BIT_PERIOD = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX    = (BIT_PERIOD > DWELL) ? BIT_PERIOD : DWELL;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         layer_q, layer_d;
  logic [5:0]         bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic               swap_pending_q, swap_pending_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_clk_q, ser_clk_d;
  logic               ser_latch_q, ser_latch_d;
  logic [7:0]         layer_en_q, layer_en_d;
  logic               frame_done_q, frame_done_d;
  logic               swap_c;

  // Sequencer: phase counter, bit index and layer index advance per state.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    swap_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d = ST_SHIFT;
          layer_d = 3'd0;
          bit_d   = 6'd0;
          cnt_d   = '0;
          swap_c  = swap_pending_q;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
          cnt_d = '0;
          if (bit_q == 6'd63) begin
            state_d = ST_LATCH;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = ST_DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DWELL: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d = '0;
          bit_d = 6'd0;
          if (layer_q == 3'd7) begin
            swap_c  = swap_pending_q;
            layer_d = 3'd0;
            state_d = scan_en ? ST_SHIFT : ST_IDLE;
          end else if (scan_en) begin
            layer_d = layer_q + 3'd1;
            state_d = ST_SHIFT;
          end else begin
            layer_d = 3'd0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Double buffer: a swap always takes the pre-edge shadow, even if a new frame lands now.
  always_comb begin
    shadow_d       = frame_valid ? frame_cube_flat : shadow_q;
    active_d       = swap_c ? shadow_q : active_q;
    swap_pending_d = frame_valid | (swap_pending_q & ~swap_c);
    drop_cnt_d     = drop_cnt_q;
    if (frame_valid && swap_pending_q && !swap_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Outputs decoded from next state so they align with the registered state.
  // Stream bit b of layer L is flat bit L*64 + 63 - b, i.e. {L, ~b}.
  always_comb begin
    ser_data_d   = (state_d == ST_SHIFT) && active_d[{layer_d, ~bit_d}];
    ser_clk_d    = (state_d == ST_SHIFT) && (cnt_d >= CNT_W'(CLK_DIV));
    ser_latch_d  = (state_d == ST_LATCH);
    layer_en_d   = (state_d == ST_DWELL) ? (8'd1 << layer_d) : 8'd0;
    frame_done_d = (state_d == ST_DWELL) && (layer_d == 3'd7) &&
                   (cnt_d == CNT_W'(DWELL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      layer_q        <= 3'd0;
      bit_q          <= 6'd0;
      cnt_q          <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      swap_pending_q <= 1'b0;
      drop_cnt_q     <= 8'd0;
      ser_data_q     <= 1'b0;
      ser_clk_q      <= 1'b0;
      ser_latch_q    <= 1'b0;
      layer_en_q     <= 8'd0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      layer_q        <= layer_d;
      bit_q          <= bit_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      swap_pending_q <= swap_pending_d;
      drop_cnt_q     <= drop_cnt_d;
      ser_data_q     <= ser_data_d;
      ser_clk_q      <= ser_clk_d;
      ser_latch_q    <= ser_latch_d;
      layer_en_q     <= layer_en_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign ser_data     = ser_data_q;
  assign ser_clk      = ser_clk_q;
  assign ser_latch    = ser_latch_q;
  assign layer_en     = layer_en_q;
  assign frame_done   = frame_done_q;
  assign swap_pending = swap_pending_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Directed bench for cube_scan_ctrl (CLK_DIV=2, DWELL=16): a pin monitor rebuilds
// the latched 64-bit layer words, and hand-computed expectations are checked.
module tb_cube_scan_ctrl;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DWELL   = 16;
  localparam int          LAYER_P = 274;
  localparam int          FRAME_P = 2192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_en = 1'b0;
  logic [511:0] frame_cube_flat = '0;
  logic         frame_valid = 1'b0;
  logic         ser_data, ser_clk, ser_latch;
  logic [7:0]   layer_en;
  logic         frame_done, swap_pending;
  logic [7:0]   drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  cube_scan_ctrl #(.CLK_DIV(CLK_DIV), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .frame_cube_flat(frame_cube_flat), .frame_valid(frame_valid),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
    .layer_en(layer_en), .frame_done(frame_done),
    .swap_pending(swap_pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: shifts on ser_clk rise, snapshots the word on ser_latch rise.
  logic [63:0] shreg = '0;
  logic [63:0] words[$];
  int          latch_t[$];
  logic [7:0]  lens[$];
  int          fds[$];
  int          sclk_rises = 0;
  int          len20_cnt  = 0;
  logic        prev_clk = 1'b0, prev_latch = 1'b0;
  logic [7:0]  prev_len = '0;

  always @(negedge clk) begin
    if (ser_clk && !prev_clk) begin
      shreg = {shreg[62:0], ser_data};
      sclk_rises++;
    end
    if (ser_latch && !prev_latch) begin
      words.push_back(shreg);
      latch_t.push_back(cyc);
    end
    if (layer_en != 8'd0 && prev_len == 8'd0) lens.push_back(layer_en);
    if (layer_en == 8'h20) len20_cnt++;
    if (frame_done) fds.push_back(cyc);
    prev_clk   = ser_clk;
    prev_latch = ser_latch;
    prev_len   = layer_en;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    words.delete(); latch_t.delete(); lens.delete(); fds.delete();
    sclk_rises = 0;
    len20_cnt  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; scan_en = 1'b0; frame_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    clr_mon();
  endtask

  task automatic pulse_frame(input logic [511:0] f);
    frame_cube_flat = f;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return words.size();
      1:       return lens.size();
      default: return fds.size();
    endcase
  endfunction

  task automatic wait_q(input string tag, input int which, input int n);
    int k = 0;
    while (qsize(which) < n && k < 20000) begin
      step();
      k++;
    end
    chk(tag, 64'(qsize(which) >= n), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] f;
    int p0, k, r;

    // Reset state
    do_reset();
    chk("rst_ser_data", 64'(ser_data), 64'd0);
    chk("rst_ser_clk", 64'(ser_clk), 64'd0);
    chk("rst_ser_latch", 64'(ser_latch), 64'd0);
    chk("rst_layer_en", 64'(layer_en), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_swap_pending", 64'(swap_pending), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Blank scan: zero words, walking layer enable, fixed periods
    scan_en = 1'b1;
    p0 = cyc + 1;
    wait_q("t1_wait_fd", 2, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_word%0d", i), words[i], 64'd0);
      chk($sformatf("t1_layer_en%0d", i), 64'(lens[i]), 64'(8'd1 << i));
    end
    chk("t1_first_latch", 64'(latch_t[0]), 64'(p0 + 256));
    chk("t1_layer_period", 64'(latch_t[1] - latch_t[0]), 64'(LAYER_P));
    chk("t1_first_fd", 64'(fds[0]), 64'(p0 + FRAME_P - 1));
    chk("t1_frame_period", 64'(fds[1] - fds[0]), 64'(FRAME_P));

    // Single frame 0x81 in byte 0 loaded before enable
    do_reset();
    f = '0; f[7:0] = 8'h81;
    pulse_frame(f);
    chk("t2_pending_set", 64'(swap_pending), 64'd1);
    scan_en = 1'b1;
    step();
    chk("t2_pending_clr", 64'(swap_pending), 64'd0);
    wait_q("t2_wait_words", 0, 8);
    chk("t2_layer0", words[0], 64'h81);
    for (int i = 1; i < 8; i++) chk($sformatf("t2_layer%0d", i), words[i], 64'd0);

    // New frame mid-layer 3 shows only from the next frame
    do_reset();
    f = '0; f[7:0] = 8'h81; f[39*8 +: 8] = 8'h11;
    pulse_frame(f);
    scan_en = 1'b1;
    wait_q("t3_wait_l2", 1, 3);
    repeat (30) step();
    f = '0; f[7:0] = 8'h3C; f[31*8 +: 8] = 8'hA5;
    pulse_frame(f);
    chk("t3_pending_mid", 64'(swap_pending), 64'd1);
    wait_q("t3_wait_fd", 2, 1);
    chk("t3_pending_at_fd", 64'(swap_pending), 64'd1);
    step();
    chk("t3_pending_after_fd", 64'(swap_pending), 64'd0);
    wait_q("t3_wait_words", 0, 13);
    chk("t3_f1_layer0", words[0], 64'h81);
    chk("t3_f1_layer4", words[4], 64'h1100_0000_0000_0000);
    chk("t3_f2_layer0", words[8], 64'h3C);
    chk("t3_f2_layer3", words[11], 64'hA500_0000_0000_0000);
    chk("t3_f2_layer4", words[12], 64'd0);

    // Three frames in one period, then a frame coincident with frame_done
    do_reset();
    scan_en = 1'b1;
    wait_q("t4_wait_l1", 1, 2);
    f = '0; f[7:0] = 8'h01; pulse_frame(f);
    step();
    f[7:0] = 8'h02; pulse_frame(f);
    step();
    f[7:0] = 8'h03; pulse_frame(f);
    chk("t4_drop2", 64'(drop_cnt), 64'd2);
    chk("t4_pending", 64'(swap_pending), 64'd1);
    wait_q("t4_wait_f2", 0, 9);
    chk("t4_third_shown", words[8], 64'h03);
    f[7:0] = 8'h05; pulse_frame(f);
    chk("t4_drop_keep", 64'(drop_cnt), 64'd2);
    k = 0;
    while (!frame_done && k < 4000) begin step(); k++; end
    chk("t4_fd_seen", 64'(frame_done), 64'd1);
    f[7:0] = 8'h04; pulse_frame(f);
    chk("t4_coinc_pending", 64'(swap_pending), 64'd1);
    chk("t4_coinc_drop", 64'(drop_cnt), 64'd2);
    wait_q("t4_wait_f3", 0, 17);
    chk("t4_old_shadow_shown", words[16], 64'h05);
    wait_q("t4_wait_f4", 0, 25);
    chk("t4_new_shown", words[24], 64'h04);

    // scan_en dropped in layer 5 shift
    do_reset();
    scan_en = 1'b1;
    wait_q("t5_wait_l4", 1, 5);
    repeat (30) step();
    scan_en = 1'b0;
    wait_q("t5_wait_l5", 1, 6);
    k = 0;
    while (layer_en != 8'd0 && k < 100) begin step(); k++; end
    chk("t5_layer_off", 64'(layer_en), 64'd0);
    repeat (300) step();
    chk("t5_words", 64'(words.size()), 64'd6);
    chk("t5_no_fd", 64'(fds.size()), 64'd0);
    chk("t5_l5_dwell", 64'(len20_cnt), 64'(DWELL));
    chk("t5_sclk_rises", 64'(sclk_rises), 64'd384);
    chk("t5_idle_clk", 64'(ser_clk), 64'd0);
    chk("t5_idle_latch", 64'(ser_latch), 64'd0);
    chk("t5_idle_data", 64'(ser_data), 64'd0);
    scan_en = 1'b1;
    wait_q("t5_wait_restart", 1, 7);
    chk("t5_restart_l0", 64'(lens[6]), 64'h01);

    // Reset during layer 2 dwell
    do_reset();
    f = '0; f[7:0] = 8'h81; pulse_frame(f);
    scan_en = 1'b1;
    wait_q("t6_wait_l0", 1, 1);
    f[7:0] = 8'h42; pulse_frame(f);
    f[7:0] = 8'h24; pulse_frame(f);
    chk("t6_drop_pre", 64'(drop_cnt), 64'd1);
    wait_q("t6_wait_l2", 1, 3);
    repeat (3) step();
    chk("t6_in_l2", 64'(layer_en), 64'h04);
    rst = 1'b1; scan_en = 1'b0;
    step();
    rst = 1'b0;
    chk("t6_layer_en", 64'(layer_en), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_pending", 64'(swap_pending), 64'd0);
    r = sclk_rises;
    repeat (20) step();
    chk("t6_idle_no_shift", 64'(sclk_rises), 64'(r));
    clr_mon();
    scan_en = 1'b1;
    wait_q("t6_wait_word", 0, 1);
    chk("t6_buffers_cleared", words[0], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
